// File: rtl/alarm_sounder_if.sv
// alarm_sounder_if: alarm/snooze controls in, audio and status flags out.
interface alarm_sounder_if;
  logic alarm;
  logic alarmen;
  logic snooze;
  logic audio;
  logic audio_sd;
  logic ringing;
  logic snoozed;
  modport master (output alarm, alarmen, snooze, input audio, audio_sd, ringing, snoozed);
  modport slave  (input alarm, alarmen, snooze, output audio, audio_sd, ringing, snoozed);
endinterface

// File: rtl/alarm_sounder.sv
// alarm_sounder: interrupted beep tone with snooze, ring timeout and enable gating.
module alarm_sounder #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int TONE_HZ     = 2000,
  parameter int BEEP_ON_MS  = 250,
  parameter int BEEP_OFF_MS = 250,
  parameter int SNOOZE_S    = 300,
  parameter int TIMEOUT_S   = 60
) (
  input logic clk,
  input logic reset,
  alarm_sounder_if.slave bus
);
  localparam int TONE_DIV = CLK_HZ / (2 * TONE_HZ);
  localparam int MS_DIV   = CLK_HZ / 1000;
  localparam int CAD      = BEEP_ON_MS + BEEP_OFF_MS;
  localparam int MAX_S    = SNOOZE_S > TIMEOUT_S ? SNOOZE_S : TIMEOUT_S;
  localparam int TW       = $clog2(TONE_DIV + 1);
  localparam int PW       = $clog2(MS_DIV + 1);
  localparam int SW       = $clog2(MAX_S + 1);
  localparam int CW       = $clog2(CAD + 1);
  typedef enum logic [1:0] {IDLE, RING, SNOOZE, DONE} state_t;
  state_t state_q, state_d;
  logic alarm_q;
  logic [2:0] snz_q;
  logic [PW-1:0] pre_q, pre_d;
  logic [9:0] ms_q, ms_d;
  logic [SW-1:0] sec_q, sec_d;
  logic [CW-1:0] cad_q, cad_d;
  logic [TW-1:0] tone_q, tone_d;
  logic audio_q, audio_d, ringing_q, snoozed_q;
  logic alarm_rise, snz_pulse, ms_tick, sec_tick, entry, on_q, on_d, restart, tone_wrap;
  always_comb begin
    alarm_rise = bus.alarm & ~alarm_q;
    snz_pulse = snz_q[1] & ~snz_q[2];
    ms_tick = pre_q == PW'(MS_DIV - 1);
    sec_tick = ms_tick && ms_q == 10'd999;
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = alarm_rise && bus.alarmen ? RING : IDLE;
      RING:    state_d = !bus.alarmen ? IDLE : snz_pulse ? SNOOZE :
                         sec_tick && sec_q == SW'(TIMEOUT_S - 1) ? DONE : RING;
      SNOOZE:  state_d = !bus.alarmen ? IDLE : sec_tick && sec_q == SW'(SNOOZE_S - 1) ? RING : SNOOZE;
      default: state_d = bus.alarmen && bus.alarm ? DONE : IDLE;
    endcase
    // every state change realigns timers and cadence to the entry edge
    entry = state_d != state_q;
    pre_d = entry || ms_tick ? '0 : pre_q + 1'b1;
    ms_d = entry || sec_tick ? '0 : ms_tick ? ms_q + 1'b1 : ms_q;
    sec_d = entry ? '0 : sec_tick ? sec_q + 1'b1 : sec_q;
    cad_d = entry || (ms_tick && cad_q == CW'(CAD - 1)) ? '0 : ms_tick ? cad_q + 1'b1 : cad_q;
    on_q = state_q == RING && cad_q < CW'(BEEP_ON_MS);
    on_d = state_d == RING && cad_d < CW'(BEEP_ON_MS);
    restart = !on_q || !on_d;
    tone_wrap = tone_q == TW'(TONE_DIV - 1);
    tone_d = restart || tone_wrap ? '0 : tone_q + 1'b1;
    audio_d = !restart && (tone_wrap ? ~audio_q : audio_q);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      alarm_q   <= 1'b0;
      snz_q     <= '0;
      pre_q     <= '0;
      ms_q      <= '0;
      sec_q     <= '0;
      cad_q     <= '0;
      tone_q    <= '0;
      audio_q   <= 1'b0;
      ringing_q <= 1'b0;
      snoozed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      alarm_q   <= bus.alarm;
      snz_q     <= {snz_q[1:0], bus.snooze};
      pre_q     <= pre_d;
      ms_q      <= ms_d;
      sec_q     <= sec_d;
      cad_q     <= cad_d;
      tone_q    <= tone_d;
      audio_q   <= audio_d;
      ringing_q <= state_d == RING;
      snoozed_q <= state_d == SNOOZE;
    end
  end
  assign bus.audio    = audio_q;
  assign bus.audio_sd = ringing_q;
  assign bus.ringing  = ringing_q;
  assign bus.snoozed  = snoozed_q;
endmodule

// File: tb/tb_alarm_sounder.sv
// tb_alarm_sounder: directed scenario tasks for alarm_sounder at scaled-down timing.
module tb_alarm_sounder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int t = 0;
  alarm_sounder_if bus();
  alarm_sounder #(.CLK_HZ(8000), .TONE_HZ(1000), .BEEP_ON_MS(2), .BEEP_OFF_MS(2),
                  .SNOOZE_S(2), .TIMEOUT_S(3)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [3:0] outs();
    return {bus.audio, bus.audio_sd, bus.ringing, bus.snoozed};
  endfunction
  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      t++;
    end
  endtask
  task automatic run_to(input int n);
    adv(n - t);
  endtask
  task automatic wait_ring(input string name);
    int n = 0;
    while (bus.ringing !== 1'b1 && n < 2) begin
      adv(1);
      n++;
    end
    checks++;
    if (bus.ringing !== 1'b1) begin errors++; $display("FAIL %s ringing=%b exp=1", name, bus.ringing); end
    t = 0;
  endtask
  task automatic test_reset();
    adv(3);
    checks++;
    if (outs() !== 4'b0000) begin errors++; $display("FAIL reset_held outs=%b exp=0000", outs()); end
    reset = 1'b0;
    adv(2);
    checks++;
    if (outs() !== 4'b0000) begin errors++; $display("FAIL reset_release outs=%b exp=0000", outs()); end
  endtask
  task automatic test_cadence();
    bus.alarmen = 1'b1;
    bus.alarm = 1'b1;
    wait_ring("cadence_entry");
    checks++;
    if (bus.audio_sd !== 1'b1) begin errors++; $display("FAIL cadence_sd audio_sd=%b exp=1", bus.audio_sd); end
    for (int j = 0; j < 40; j++) begin
      logic e;
      e = ((j % 32) < 16) && (((j % 32) / 4) % 2 == 1);
      checks++;
      if (bus.audio !== e) begin errors++; $display("FAIL cadence t=%0d audio=%b exp=%b", j, bus.audio, e); end
      adv(1);
    end
  endtask
  task automatic test_timeout();
    run_to(23999);
    checks++;
    if (bus.ringing !== 1'b1) begin errors++; $display("FAIL timeout_before ringing=%b exp=1", bus.ringing); end
    adv(1);
    checks++;
    if (outs() !== 4'b0000) begin errors++; $display("FAIL timeout_edge outs=%b exp=0000", outs()); end
    adv(100);
    checks++;
    if (outs() !== 4'b0000) begin errors++; $display("FAIL done_no_retrigger outs=%b exp=0000", outs()); end
    bus.alarm = 1'b0;
    adv(2);
    checks++;
    if (outs() !== 4'b0000) begin errors++; $display("FAIL done_to_idle outs=%b exp=0000", outs()); end
  endtask
  task automatic test_snooze();
    bus.alarm = 1'b1;
    wait_ring("snooze_entry");
    bus.alarm = 1'b0;
    run_to(100);
    checks++;
    if (bus.ringing !== 1'b1) begin errors++; $display("FAIL ring_latched ringing=%b exp=1", bus.ringing); end
    bus.snooze = 1'b1;
    adv(2);
    checks++;
    if ({bus.ringing, bus.snoozed} !== 2'b10) begin
      errors++; $display("FAIL snooze_early ring_snz=%b exp=10", {bus.ringing, bus.snoozed});
    end
    adv(1);
    checks++;
    if (outs() !== 4'b0001) begin errors++; $display("FAIL snooze_latency outs=%b exp=0001", outs()); end
    bus.snooze = 1'b0;
    run_to(5103);
    bus.snooze = 1'b1;
    adv(3);
    bus.snooze = 1'b0;
    run_to(16102);
    checks++;
    if (outs() !== 4'b0001) begin errors++; $display("FAIL snooze_hold outs=%b exp=0001", outs()); end
    adv(1);
    checks++;
    if (outs() !== 4'b0110) begin errors++; $display("FAIL snooze_expiry outs=%b exp=0110", outs()); end
    run_to(16106);
    checks++;
    if (bus.audio !== 1'b0) begin errors++; $display("FAIL resume_tone_pre audio=%b exp=0", bus.audio); end
    adv(1);
    checks++;
    if (bus.audio !== 1'b1) begin errors++; $display("FAIL resume_tone audio=%b exp=1", bus.audio); end
  endtask
  task automatic test_priority();
    run_to(40100);
    bus.snooze = 1'b1;
    adv(2);
    checks++;
    if (bus.ringing !== 1'b1) begin errors++; $display("FAIL fresh_timeout ringing=%b exp=1", bus.ringing); end
    adv(1);
    checks++;
    if (outs() !== 4'b0001) begin errors++; $display("FAIL snooze_beats_timeout outs=%b exp=0001", outs()); end
    bus.snooze = 1'b0;
    run_to(40110);
    bus.alarmen = 1'b0;
    adv(1);
    checks++;
    if (outs() !== 4'b0000) begin errors++; $display("FAIL disable_in_snooze outs=%b exp=0000", outs()); end
    bus.alarmen = 1'b1;
    adv(5);
    checks++;
    if (outs() !== 4'b0000) begin errors++; $display("FAIL idle_after_disable outs=%b exp=0000", outs()); end
  endtask
  task automatic test_disabled();
    bus.alarmen = 1'b0;
    bus.alarm = 1'b0;
    adv(2);
    bus.alarm = 1'b1;
    adv(3);
    checks++;
    if (outs() !== 4'b0000) begin errors++; $display("FAIL disabled_rise outs=%b exp=0000", outs()); end
    bus.alarmen = 1'b1;
    adv(3);
    checks++;
    if (outs() !== 4'b0000) begin errors++; $display("FAIL enable_no_edge outs=%b exp=0000", outs()); end
  endtask
  task automatic test_reset_mid_ring();
    bus.alarm = 1'b0;
    adv(2);
    bus.alarm = 1'b1;
    wait_ring("reset_ring_entry");
    run_to(5);
    checks++;
    if (bus.audio !== 1'b1) begin errors++; $display("FAIL pre_reset_tone audio=%b exp=1", bus.audio); end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (outs() !== 4'b0000) begin errors++; $display("FAIL async_reset outs=%b exp=0000", outs()); end
    bus.alarm = 1'b0;
    adv(2);
    reset = 1'b0;
    adv(5);
    checks++;
    if (outs() !== 4'b0000) begin errors++; $display("FAIL post_reset_idle outs=%b exp=0000", outs()); end
  endtask
  initial begin
    bus.alarm = 1'b0;
    bus.alarmen = 1'b0;
    bus.snooze = 1'b0;
    test_reset();
    test_cadence();
    test_timeout();
    test_snooze();
    test_priority();
    test_disabled();
    test_reset_mid_ring();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog t=%0d exp=finished", t);
    $fatal(1, "watchdog expired");
  end
endmodule
